// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data access
// Round-robin on ties, registered request capture, optional access timeout with sticky err.
module mem_port_arbiter #(
   parameter int              AW       = 32,
   parameter int              DW       = 32,
   parameter int              TIMEOUT  = 16,
   parameter logic [DW-1:0]   ERR_DATA = DW'(32'hDEADBEEF)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_done,
   output logic          mem_valid,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          stall,
   output logic          err
);

   localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t        state, state_nx;
   logic          gnt_d;
   logic          last_d;
   logic          we_r;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] wdata_r;
   logic [CW-1:0] cnt;

   logic          grant;
   logic          grant_sel_d;
   logic          complete;
   logic          timed_out;

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      grant       = 1'b0;
      grant_sel_d = 1'b0;
      complete    = 1'b0;
      timed_out   = 1'b0;
      case (state)
         S_IDLE: begin
            if (if_req || dm_req) begin
               grant = 1'b1;
               // On a tie the port that did not win last time gets the memory.
               grant_sel_d = dm_req && (!if_req || !last_d);
               state_nx    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (mem_ready) begin
               complete = 1'b1;
               state_nx = S_RESP;
            end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
               timed_out = 1'b1;
               state_nx  = S_RESP;
            end
         end
         S_RESP:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         gnt_d    <= 1'b0;
         last_d   <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= '0;
         wdata_r  <= '0;
         cnt      <= '0;
         if_rdata <= '0;
         dm_rdata <= '0;
         err      <= 1'b0;
      end else begin
         if (grant) begin
            gnt_d   <= grant_sel_d;
            last_d  <= grant_sel_d;
            we_r    <= grant_sel_d & dm_we;
            addr_r  <= grant_sel_d ? dm_addr : if_addr;
            wdata_r <= grant_sel_d ? dm_wdata : '0;
            cnt     <= '0;
         end else if (state == S_ACCESS && !complete && !timed_out && cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
         end

         if (complete || timed_out) begin
            if (gnt_d) begin
               if (!we_r) dm_rdata <= complete ? mem_rdata : ERR_DATA;
            end else begin
               if_rdata <= complete ? mem_rdata : ERR_DATA;
            end
         end

         if (timed_out) err <= 1'b1;
      end
   end

   assign mem_valid = (state == S_ACCESS);
   assign mem_we    = mem_valid & we_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign if_done   = (state == S_RESP) & ~gnt_d;
   assign dm_done   = (state == S_RESP) &  gnt_d;
   assign stall     = (if_req & ~if_done) | (dm_req & ~dm_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Transaction-timing model compared every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam int INF = 1 << 30;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_done;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [DW-1:0] dm_rdata;
   logic          dm_done;
   logic          mem_valid;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic          stall;
   logic          err;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) dut (
      .CLK(CLK), .RST(RST),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .err(err)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory responder: ready after lat ACCESS cycles (0 = never), or always when tied.
   int lat = 1;
   bit tie = 1'b0;
   int acc = 0;
   always @(posedge CLK) begin
      #1;
      if (mem_valid === 1'b1) acc++;
      else acc = 0;
      mem_ready = tie || (mem_valid === 1'b1 && lat != 0 && acc >= lat);
      mem_rdata = mem_addr ^ 32'h2001001A;
   end

   // Model: each access is a grant cycle, valid cycles after it, and a done cycle.
   bit            mon_en = 1'b0;
   int            m_port = 0;
   bit            m_last_d = 1'b0;
   int            m_start = 0;
   int            m_done = INF;
   int            m_err_at = INF;
   bit            m_we = 1'b0;
   bit            m_pend_apply = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_pend = '0;
   logic [DW-1:0] m_if_rd = '0;
   logic [DW-1:0] m_dm_rd = '0;
   bit            m_err = 1'b0;

   always @(negedge CLK) begin : model
      bit e_valid, e_ifd, e_dmd, idle_now, pick_d;
      if (mon_en) begin
         idle_now = (m_port == 0);
         e_valid  = !idle_now && cyc > m_start && cyc < m_done;
         e_ifd    = (m_port == 1) && cyc == m_done;
         e_dmd    = (m_port == 2) && cyc == m_done;
         if (cyc == m_done && m_pend_apply) begin
            if (m_port == 1) m_if_rd = m_pend;
            else             m_dm_rd = m_pend;
         end
         if (cyc == m_err_at) m_err = 1'b1;

         chk("m_valid",    mem_valid, e_valid);
         chk("m_if_done",  if_done,   e_ifd);
         chk("m_dm_done",  dm_done,   e_dmd);
         chk("m_if_rdata", if_rdata,  m_if_rd);
         chk("m_dm_rdata", dm_rdata,  m_dm_rd);
         chk("m_err",      err,       m_err);
         chk("m_stall",    stall,     (if_req & ~e_ifd) | (dm_req & ~e_dmd));
         if (e_valid) begin
            chk("m_we",   mem_we,   m_we);
            chk("m_addr", mem_addr, m_addr);
            if (m_we) chk("m_wdata", mem_wdata, m_wdata);
         end
      end

      if (RST) begin
         m_port = 0; m_last_d = 1'b0; m_done = INF; m_err_at = INF; m_err = 1'b0;
         m_if_rd = '0; m_dm_rd = '0; m_pend_apply = 1'b0;
      end else if (mon_en) begin
         if (e_valid) begin
            if (mem_ready) begin
               m_done = cyc + 1; m_pend_apply = !m_we; m_pend = mem_rdata;
            end else if (TO != 0 && cyc - m_start == TO) begin
               m_done = cyc + 1; m_err_at = cyc + 1; m_pend_apply = !m_we; m_pend = 32'hDEADBEEF;
            end
         end
         if (e_ifd || e_dmd) begin
            m_port = 0;
            m_done = INF;
         end else if (idle_now && (if_req || dm_req)) begin
            if (if_req && dm_req) pick_d = (m_last_d == 1'b0);
            else                  pick_d = dm_req;
            m_port   = pick_d ? 2 : 1;
            m_last_d = pick_d;
            m_start  = cyc;
            m_done   = INF;
            m_we     = pick_d && dm_we;
            m_addr   = pick_d ? dm_addr : if_addr;
            m_wdata  = dm_wdata;
         end
      end
   end

   task automatic wait_done(input bit d, output int at);
      at = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge CLK);
         if (d ? dm_done : if_done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("done_timeout", 0, 1);
   endtask

   int t0, td, ti, nv, ndone;
   int seq_port[4];
   int seq_cyc[4];
   bit found;

   initial begin
      repeat (3) @(posedge CLK);
      mon_en = 1'b1;
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_valid", mem_valid, 0);
      chk("rst_we",    mem_we,    0);
      chk("rst_addr",  mem_addr,  0);
      chk("rst_ifrd",  if_rdata,  0);
      chk("rst_dmrd",  dm_rdata,  0);
      chk("rst_err",   err,       0);
      chk("rst_stall", stall,     0);

      // 1: single instruction fetch, ready on first ACCESS cycle
      @(posedge CLK); #1;
      lat = 1; if_addr = 32'h10; if_req = 1'b1; t0 = cyc;
      @(negedge CLK); chk("t1_stall_wait", stall, 1);
      @(negedge CLK);
      chk("t1_valid", mem_valid, 1);
      chk("t1_addr",  mem_addr, 32'h10);
      chk("t1_we",    mem_we, 0);
      wait_done(1'b0, td);
      chk("t1_latency", td - t0, 2);
      chk("t1_rdata", if_rdata, 32'h2001000A);
      chk("t1_stall_done", stall, 0);
      @(posedge CLK); #1 if_req = 1'b0;

      // 2: simultaneous requests, data wins first tie
      @(posedge CLK); #1;
      tie = 1'b1;
      if_addr = 32'h20; if_req = 1'b1;
      dm_we = 1'b0; dm_addr = 32'h40; dm_req = 1'b1; t0 = cyc;
      @(negedge CLK); @(negedge CLK);
      chk("t2_addr_first", mem_addr, 32'h40);
      wait_done(1'b1, td);
      chk("t2_dm_latency", td - t0, 2);
      chk("t2_dm_rdata", dm_rdata, 32'h2001005A);
      @(posedge CLK); #1 dm_req = 1'b0;
      wait_done(1'b0, ti);
      chk("t2_if_after", ti - td, 3);
      chk("t2_if_rdata", if_rdata, 32'h2001003A);
      @(posedge CLK); #1 if_req = 1'b0; tie = 1'b0;

      // 3: store with three ACCESS cycles
      @(posedge CLK); #1;
      lat = 3; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h12345678; dm_req = 1'b1;
      nv = 0; found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge CLK);
         if (mem_valid) begin
            nv++;
            chk("t3_we", mem_we, 1);
            chk("t3_addr", mem_addr, 32'h80);
            chk("t3_wdata", mem_wdata, 32'h12345678);
         end
         if (dm_done) found = 1'b1;
      end
      chk("t3_found", found, 1);
      chk("t3_valid_cycles", nv, 3);
      chk("t3_dm_rdata_kept", dm_rdata, 32'h2001005A);
      @(posedge CLK); #1 dm_req = 1'b0; dm_we = 1'b0;
      @(negedge CLK); chk("t3_single_done", dm_done, 0);

      // 4: load that never gets ready -> timeout
      @(posedge CLK); #1;
      lat = 0; dm_addr = 32'h44; dm_req = 1'b1;
      nv = 0; found = 1'b0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge CLK);
         if (mem_valid) nv++;
         if (dm_done) found = 1'b1;
      end
      chk("t4_found", found, 1);
      chk("t4_valid_cycles", nv, 4);
      chk("t4_rdata", dm_rdata, 32'hDEADBEEF);
      chk("t4_err", err, 1);
      @(posedge CLK); #1 dm_req = 1'b0;
      repeat (3) @(negedge CLK);
      chk("t4_err_sticky", err, 1);

      // 5: reset in the second ACCESS cycle of a fetch
      @(posedge CLK); #1;
      lat = 0; if_addr = 32'h30; if_req = 1'b1;
      @(negedge CLK); @(negedge CLK);
      chk("t5_valid_pre", mem_valid, 1);
      @(posedge CLK); #1 RST = 1'b1; if_req = 1'b0;
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      chk("t5_valid", mem_valid, 0);
      chk("t5_we",    mem_we, 0);
      chk("t5_addr",  mem_addr, 0);
      chk("t5_err",   err, 0);
      chk("t5_ifrd",  if_rdata, 0);
      chk("t5_dmrd",  dm_rdata, 0);
      ndone = 0;
      for (int n = 0; n < 6; n++) begin
         if (if_done) ndone++;
         @(negedge CLK);
      end
      chk("t5_no_done", ndone, 0);

      // 6: both held high -> D,I,D,I every three cycles
      @(posedge CLK); #1;
      lat = 1; tie = 1'b1;
      if_addr = 32'h50; dm_addr = 32'h60; dm_we = 1'b0;
      if_req = 1'b1; dm_req = 1'b1; t0 = cyc;
      ndone = 0;
      for (int n = 0; n < 30 && ndone < 4; n++) begin
         @(negedge CLK);
         if (if_done && dm_done) chk("t6_both_done", 1, 0);
         if (if_done || dm_done) begin
            seq_port[ndone] = dm_done ? 2 : 1;
            seq_cyc[ndone]  = cyc;
            ndone++;
         end
      end
      @(posedge CLK); #1 if_req = 1'b0; dm_req = 1'b0; tie = 1'b0;
      chk("t6_count", ndone, 4);
      if (ndone == 4) begin
         chk("t6_p0", seq_port[0], 2); chk("t6_c0", seq_cyc[0] - t0, 2);
         chk("t6_p1", seq_port[1], 1); chk("t6_c1", seq_cyc[1] - t0, 5);
         chk("t6_p2", seq_port[2], 2); chk("t6_c2", seq_cyc[2] - t0, 8);
         chk("t6_p3", seq_port[3], 1); chk("t6_c3", seq_cyc[3] - t0, 11);
      end
      chk("t6_dm_rdata", dm_rdata, 32'h2001007A);
      chk("t6_if_rdata", if_rdata, 32'h2001004A);

      repeat (4) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
